// File: rtl/demux1x4_tdm.sv
// Time-division 1:4 demultiplexer: splits a slot-cycled sample stream back into a 4-slot parallel frame.
// Optional feature: define DEMUX_SYNC_CHECK_EN to resynchronise on a misaligned sof in RUN and pulse sync_err.
module demux1x4_tdm #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   din,
  input  logic               din_valid,
  input  logic               sof,
  output logic [4*WIDTH-1:0] d,
  output logic               frame_valid,
  output logic [1:0]         slot,
  output logic [7:0]         frames,
  output logic               sync_err,
  output logic               dbg_state
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         slot_q, slot_d;
  logic [WIDTH-1:0]   sh0_q, sh0_d;
  logic [WIDTH-1:0]   sh1_q, sh1_d;
  logic [WIDTH-1:0]   sh2_q, sh2_d;
  logic [4*WIDTH-1:0] d_q, d_d;
  logic               fv_q, fv_d;
  logic [7:0]         frames_q, frames_d;
  logic               se_q, se_d;
  logic               resync;

`ifdef DEMUX_SYNC_CHECK_EN
  assign resync = sof && (slot_q != 2'd0);
`else
  // Without the check, framing in RUN relies solely on the slot counter.
  assign resync = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    sh0_d    = sh0_q;
    sh1_d    = sh1_q;
    sh2_d    = sh2_q;
    d_d      = d_q;
    fv_d     = 1'b0;
    frames_d = frames_q;
    se_d     = 1'b0;
    if (din_valid) begin
      if (state_q == IDLE) begin
        if (sof) begin
          sh0_d   = din;
          slot_d  = 2'd1;
          state_d = RUN;
        end
      end else if (resync) begin
        // Partial frame is dropped; this sample starts a new frame.
        se_d   = 1'b1;
        sh0_d  = din;
        slot_d = 2'd1;
      end else begin
        case (slot_q)
          2'd0: begin
            sh0_d  = din;
            slot_d = 2'd1;
          end
          2'd1: begin
            sh1_d  = din;
            slot_d = 2'd2;
          end
          2'd2: begin
            sh2_d  = din;
            slot_d = 2'd3;
          end
          default: begin
            d_d      = {din, sh2_q, sh1_q, sh0_q};
            fv_d     = 1'b1;
            frames_d = frames_q + 8'd1;
            slot_d   = 2'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      slot_q   <= 2'd0;
      sh0_q    <= '0;
      sh1_q    <= '0;
      sh2_q    <= '0;
      d_q      <= '0;
      fv_q     <= 1'b0;
      frames_q <= 8'd0;
      se_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      sh0_q    <= sh0_d;
      sh1_q    <= sh1_d;
      sh2_q    <= sh2_d;
      d_q      <= d_d;
      fv_q     <= fv_d;
      frames_q <= frames_d;
      se_q     <= se_d;
    end
  end

  assign d           = d_q;
  assign frame_valid = fv_q;
  assign slot        = slot_q;
  assign frames      = frames_q;
  assign sync_err    = se_q;
  assign dbg_state   = state_q;

endmodule
